wb_port_arbiter: RTL and testbench

Sequential controller for the register-file writeback port and its 4:1 writeback source mux (0 = ALU result, 1 = load data, 2 = PC+4 link, 3 = accelerator result). It decodes the writeback class of the instruction leaving the EX/MEM stage and holds the core during outstanding loads. It also shares the single write port with the GEMM accelerator's result stream, using a starvation-bounded priority scheme. The block sits between the core pipeline control, the data-memory load response and the accelerator result interface. It drives the mux select and the register-file write enable.

---
 rtl/wb_port_arbiter.sv | 79 +++++++
 tb/tb_wb_port_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: register-file writeback port arbiter (ALU/load/link/accelerator) with load stall FSM
// Ports: clk, rst_n (async active-low); ex_valid/ex_cls/ex_rd from EX/MEM; ld_valid load return pulse;
// acc_req/acc_rd/acc_gnt accelerator result handshake; stall to core; wb_sel/rf_we/rf_rd registered writeback.
// Macro WB_ACC_PORT_EN enables accelerator sharing with a starvation-bounded forced grant.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic [1:0]      ex_cls,
  input  logic [RD_W-1:0] ex_rd,
  input  logic            ld_valid,
  input  logic            acc_req,
  input  logic [RD_W-1:0] acc_rd,
  output logic            acc_gnt,
  output logic            stall,
  output logic [1:0]      wb_sel,
  output logic            rf_we,
  output logic [RD_W-1:0] rf_rd
);
  typedef enum logic {RUN, LD_WAIT} state_t;
  state_t state_q, state_d;
  logic [RD_W-1:0] ld_rd_q, ld_rd_d, rf_rd_q, rf_rd_d;
  logic [1:0] wb_sel_q, wb_sel_d;
  logic rf_we_q, rf_we_d;
  logic run, core_wr, core_ld, ld_ret, gnt;
  assign run = state_q == RUN;
  assign core_wr = run && ex_valid && (ex_cls == 2'd0 || ex_cls == 2'd2);
  assign core_ld = run && ex_valid && ex_cls == 2'd1;
  assign ld_ret = !run && ld_valid;
`ifdef WB_ACC_PORT_EN
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;
  // In LD_WAIT the returning load always wins; a saturated counter simply waits for the next free cycle.
  assign gnt = acc_req && (run ? (starve_q == LIM || !(core_wr || core_ld)) : !ld_valid);
  always_comb starve_d = (acc_req && !gnt) ? (starve_q == LIM ? LIM : starve_q + 4'd1) : 4'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) starve_q <= 4'd0;
    else starve_q <= starve_d;
`else
  logic unused_acc;
  assign unused_acc = ^{acc_req, acc_rd};
  assign gnt = 1'b0;
`endif
  assign acc_gnt = gnt;
  assign stall = run ? (core_ld || (core_wr && gnt)) : !ld_valid;
  always_comb begin
    state_d = state_q;
    ld_rd_d = ld_rd_q;
    if (core_ld && !gnt) begin
      state_d = LD_WAIT;
      ld_rd_d = ex_rd;
    end
    if (ld_ret) state_d = RUN;
    // ALU/LINK class encodings equal their mux selects (0/2).
    wb_sel_d = gnt ? 2'd3 : core_wr ? ex_cls : ld_ret ? 2'd1 : wb_sel_q;
    rf_rd_d = gnt ? acc_rd : core_wr ? ex_rd : ld_ret ? ld_rd_q : rf_rd_q;
    rf_we_d = (gnt || core_wr || ld_ret) && rf_rd_d != '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      ld_rd_q <= '0;
      wb_sel_q <= 2'd0;
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
    end else begin
      state_q <= state_d;
      ld_rd_q <= ld_rd_d;
      wb_sel_q <= wb_sel_d;
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
    end
  assign wb_sel = wb_sel_q;
  assign rf_we = rf_we_q;
  assign rf_rd = rf_rd_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed plus randomized checks of wb_port_arbiter against a behavioural model
module tb_wb_port_arbiter;
  localparam int LIM = 4;
`ifdef WB_ACC_PORT_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ex_valid = 1'b0, ld_valid = 1'b0, acc_req = 1'b0;
  logic [1:0] ex_cls = 2'd0;
  logic [4:0] ex_rd = 5'd0, acc_rd = 5'd0;
  logic acc_gnt, stall, rf_we;
  logic [1:0] wb_sel;
  logic [4:0] rf_rd;
  int errors = 0, checks = 0;
  bit m_loading, m_we, n_loading, n_upd, e_gnt, e_stall;
  int m_ld_rd, m_starve, m_sel, m_rd, n_ld_rd, n_starve, n_sel, n_rd;
  always #5 clk = ~clk;
  wb_port_arbiter #(.STARVE_LIMIT(LIM), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_cls(ex_cls), .ex_rd(ex_rd),
    .ld_valid(ld_valid), .acc_req(acc_req), .acc_rd(acc_rd), .acc_gnt(acc_gnt),
    .stall(stall), .wb_sel(wb_sel), .rf_we(rf_we), .rf_rd(rf_rd)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic mreset();
    m_loading = 0; m_we = 0; m_ld_rd = 0; m_starve = 0; m_sel = 0; m_rd = 0;
  endtask
  // Model: who owns the write port this cycle, decided from the arbitration rules directly.
  function automatic void eval();
    bit want, forced;
    e_gnt = 0; e_stall = 0; n_upd = 0; n_sel = m_sel; n_rd = m_rd;
    n_loading = m_loading; n_ld_rd = m_ld_rd;
    if (m_loading) begin
      if (ld_valid) begin
        n_upd = 1; n_sel = 1; n_rd = m_ld_rd; n_loading = 0;
      end else begin
        e_stall = 1;
        if (ACC && acc_req) begin e_gnt = 1; n_upd = 1; n_sel = 3; n_rd = int'(acc_rd); end
      end
    end else begin
      want = ex_valid && ex_cls != 2'd3;
      forced = ACC && acc_req && m_starve >= LIM;
      if (forced || (ACC && acc_req && !want)) begin
        e_gnt = 1; e_stall = want; n_upd = 1; n_sel = 3; n_rd = int'(acc_rd);
      end else if (want) begin
        if (ex_cls == 2'd1) begin
          e_stall = 1; n_loading = 1; n_ld_rd = int'(ex_rd);
        end else begin
          n_upd = 1; n_sel = int'(ex_cls); n_rd = int'(ex_rd);
        end
      end
    end
    n_starve = (ACC && acc_req && !e_gnt) ? ((m_starve + 1 > LIM) ? LIM : m_starve + 1) : 0;
  endfunction
  task automatic step();
    #2;
    eval();
    chk("acc_gnt", acc_gnt, e_gnt);
    chk("stall", stall, e_stall);
    chk("rf_we", rf_we, m_we);
    chk("wb_sel", wb_sel, m_sel);
    chk("rf_rd", rf_rd, m_rd);
    @(posedge clk);
    m_we = n_upd && n_rd != 0;
    m_sel = n_sel; m_rd = n_rd; m_loading = n_loading; m_ld_rd = n_ld_rd; m_starve = n_starve;
    @(negedge clk);
  endtask
  task automatic idle();
    ex_valid = 0; ex_cls = 0; ex_rd = 0; ld_valid = 0; acc_req = 0; acc_rd = 0;
  endtask
  initial begin
    mreset();
    #1;
    chk("rst_we", rf_we, 0); chk("rst_sel", wb_sel, 0); chk("rst_rd", rf_rd, 0);
    chk("rst_gnt", acc_gnt, 0); chk("rst_stall", stall, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    ex_valid = 1; ex_cls = 0; ex_rd = 7;
    #1 chk("alu_stall", stall, 0);
    step();
    idle();
    chk("alu_we", rf_we, 1); chk("alu_sel", wb_sel, 0); chk("alu_rd", rf_rd, 7);
    step();
    ex_valid = 1; ex_cls = 1; ex_rd = 9;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ld_stall", stall, 1);
      step();
      ex_cls = 0; ex_rd = 4;
    end
    ld_valid = 1;
    #1 chk("ld_ret_stall", stall, 0);
    step();
    idle();
    chk("ld_we", rf_we, 1); chk("ld_sel", wb_sel, 1); chk("ld_rd", rf_rd, 9);
    step();
`ifdef WB_ACC_PORT_EN
    ex_valid = 1; ex_cls = 1; ex_rd = 5;
    step();
    idle(); acc_req = 1; acc_rd = 12;
    #1 chk("acc_ldw_gnt", acc_gnt, 1);
    step();
    idle();
    chk("acc_we", rf_we, 1); chk("acc_sel", wb_sel, 3); chk("acc_rd", rf_rd, 12);
    ld_valid = 1;
    step();
    idle();
    step();
    ex_valid = 1; ex_cls = 0; ex_rd = 3; acc_req = 1; acc_rd = 20;
    for (int i = 0; i <= LIM; i++) begin
      #1 chk("starve_gnt", acc_gnt, i == LIM);
      chk("starve_stall", stall, i == LIM);
      step();
    end
    acc_req = 0;
    chk("forced_sel", wb_sel, 3); chk("forced_rd", rf_rd, 20);
    #1 chk("resume_stall", stall, 0);
    step();
    chk("resume_sel", wb_sel, 0); chk("resume_rd", rf_rd, 3);
    idle(); acc_req = 1; acc_rd = 0;
    #1 chk("acc0_gnt", acc_gnt, 1);
    step();
    idle();
    chk("acc0_we", rf_we, 0); chk("acc0_sel", wb_sel, 3);
    step();
`endif
    ex_valid = 1; ex_cls = 2; ex_rd = 0;
    step();
    idle();
    chk("link0_we", rf_we, 0); chk("link0_sel", wb_sel, 2);
    step();
    ex_valid = 1; ex_cls = 1; ex_rd = 11;
    step();
    idle();
    step();
    #1 rst_n = 0;
    mreset();
    #1 chk("midrst_stall", stall, 0); chk("midrst_we", rf_we, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1; ld_valid = 1;
    step();
    idle();
    chk("postrst_we", rf_we, 0);
    step();
    for (int i = 0; i < 3000; i++) begin
      ex_valid = $urandom_range(0, 3) != 0;
      ex_cls = 2'($urandom_range(0, 3));
      ex_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ld_valid = $urandom_range(0, 3) == 0;
      if (e_gnt) acc_req = 0;
      if (!acc_req && $urandom_range(0, 2) == 0) begin
        acc_req = 1;
        acc_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      end
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
